calc_key_sequencer: RTL

//   Consumes decoded key flags from the 4x4 keyboard scanner and assembles a calculator request.

---
 rtl/calc_pkg.sv | 18 +
 rtl/key_event_edge.sv | 48 ++++
 rtl/calc_key_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: operator codes,
// sequencer states and the largest legal BCD digit.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_ENTRY_A,
    ST_ENTRY_B,
    ST_ISSUE
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/key_event_edge.sv
// Turns the level key flags from the keyboard scanner into single-cycle
// events. It fires on the rising edge of "any key held" and picks one
// event with priority eq > op > num. The key value is captured in the
// same edge cycle.
module key_event_edge
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       is_num,
  input  logic       is_op,
  input  logic       is_eq,
  input  logic [3:0] num_val,
  input  logic [1:0] op_val,
  output logic       ev_num,
  output logic       ev_op,
  output logic       ev_eq,
  output logic [3:0] ev_num_val,
  output logic [1:0] ev_op_val
);

  logic key_any;
  logic key_q;
  logic key_rise;

  assign key_any  = is_num | is_op | is_eq;
  assign key_rise = key_any & ~key_q;

  // Edge register plus one registered, priority-encoded event per key press.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= 1'b0;
      ev_num     <= 1'b0;
      ev_op      <= 1'b0;
      ev_eq      <= 1'b0;
      ev_num_val <= '0;
      ev_op_val  <= '0;
    end else begin
      key_q      <= key_any;
      ev_eq      <= key_rise & is_eq;
      ev_op      <= key_rise & is_op & ~is_eq;
      ev_num     <= key_rise & is_num & ~is_op & ~is_eq;
      ev_num_val <= num_val;
      ev_op_val  <= op_val;
    end
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Builds a calculator request "A <op> B =" from decoded key events.
// Operands are packed BCD, with the most significant digit in the high
// nibble. The request is handed to the arithmetic stage over valid/ready.
// Optional feature macro: CALC_OP_REPLACE_EN. When it is defined, an
// operator pressed before any B digit replaces the latched operator.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    is_num,
  input  logic                    is_op,
  input  logic                    is_eq,
  input  logic [3:0]              num_val,
  input  logic [1:0]              op_val,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [4*NUM_DIGITS-1:0] req_a,
  output logic [4*NUM_DIGITS-1:0] req_b,
  output logic [1:0]              req_op,
  output logic [4*NUM_DIGITS-1:0] disp_bcd,
  output logic                    disp_sel,
  output logic                    digit_ovf
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);

  logic          ev_num;
  logic          ev_op;
  logic          ev_eq;
  logic [3:0]    ev_num_val;
  logic [1:0]    ev_op_val;

  state_t        state_q, state_n;
  logic [W-1:0]  a_q, a_n;
  logic [W-1:0]  b_q, b_n;
  logic [1:0]    op_q, op_n;
  logic [CW-1:0] cnt_a_q, cnt_a_n;
  logic [CW-1:0] cnt_b_q, cnt_b_n;
  logic          ovf_q, ovf_n;
  logic          digit_ok;

  key_event_edge u_key_event_edge (
    .clk        (clk),
    .rst        (rst),
    .is_num     (is_num),
    .is_op      (is_op),
    .is_eq      (is_eq),
    .num_val    (num_val),
    .op_val     (op_val),
    .ev_num     (ev_num),
    .ev_op      (ev_op),
    .ev_eq      (ev_eq),
    .ev_num_val (ev_num_val),
    .ev_op_val  (ev_op_val)
  );

  assign digit_ok = ev_num && (ev_num_val <= BCD_MAX);

  // State register together with the operand, operator, count and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ENTRY_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      cnt_a_q <= cnt_a_n;
      cnt_b_q <= cnt_b_n;
      ovf_q   <= ovf_n;
    end
  end

  // Next-state logic: apply at most one key event per cycle to the operand being edited.
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    cnt_a_n = cnt_a_q;
    cnt_b_n = cnt_b_q;
    ovf_n   = 1'b0;
    unique case (state_q)
      ST_ENTRY_A: begin
        // An operand with no digits entered is already zero, so it needs no explicit clear.
        if (ev_op) begin
          op_n    = ev_op_val;
          state_n = ST_ENTRY_B;
        end else if (digit_ok) begin
          if (cnt_a_q < CNT_FULL) begin
            a_n     = {a_q[W-5:0], ev_num_val};
            cnt_a_n = cnt_a_q + CW'(1);
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      ST_ENTRY_B: begin
        if (ev_eq) begin
          state_n = ST_ISSUE;
`ifdef CALC_OP_REPLACE_EN
        end else if (ev_op && (cnt_b_q == '0)) begin
          op_n = ev_op_val;
`endif
        end else if (digit_ok) begin
          if (cnt_b_q < CNT_FULL) begin
            b_n     = {b_q[W-5:0], ev_num_val};
            cnt_b_n = cnt_b_q + CW'(1);
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          a_n     = '0;
          b_n     = '0;
          cnt_a_n = '0;
          cnt_b_n = '0;
          state_n = ST_ENTRY_A;
        end
      end
      default: state_n = ST_ENTRY_A;
    endcase
  end

  assign req_valid = (state_q == ST_ISSUE);
  assign req_a     = a_q;
  assign req_b     = b_q;
  assign req_op    = op_q;
  assign disp_sel  = (state_q != ST_ENTRY_A);
  assign disp_bcd  = (state_q == ST_ENTRY_A) ? a_q : b_q;
  assign digit_ovf = ovf_q;

endmodule
